// File: rtl/game_pkg.sv
// Shared types and constants for the snake game phase controller.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } game_state_t;

  localparam int SCORE_DIGITS = 3;
  localparam int SCORE_W      = 4 * SCORE_DIGITS;

endpackage

// File: rtl/game_sequencer_bcd_counter.sv
// N-digit packed BCD counter with clear, increment and saturation at all nines.
module bcd_counter #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_inc,
  output logic [4*DIGITS-1:0]   o_value,
  output logic [4*DIGITS-1:0]   o_next
);

  logic [4*DIGITS-1:0] val_q, val_d;
  logic                all9;
  logic                carry;

  always_comb begin
    val_d = val_q;
    all9  = 1'b1;
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (val_q[4*k +: 4] != 4'd9) all9 = 1'b0;
    end
    if (i_clr) begin
      val_d = '0;
    end else if (i_inc && !all9) begin
      // Ripple the carry digit by digit; a 9 rolls to 0 and passes it on.
      for (int k = 0; k < DIGITS; k++) begin
        if (carry) begin
          if (val_q[4*k +: 4] == 4'd9) begin
            val_d[4*k +: 4] = 4'd0;
          end else begin
            val_d[4*k +: 4] = val_q[4*k +: 4] + 4'd1;
            carry           = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign o_value = val_q;
  assign o_next  = val_d;

endmodule

// File: rtl/game_sequencer.sv
// Snake game phase controller: IDLE/COUNT/PLAY/PAUSE/OVER/WIN, BCD score and high score.
// Define GAME_SEQ_AUTORESTART_EN to let OVER/WIN time out back to IDLE after END_FRAMES frames.
module game_sequencer
  import game_pkg::*;
#(
  parameter int COUNTDOWN_FRAMES = 60,
  parameter int END_FRAMES       = 600
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_restart,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_vsync,
  input  logic               i_failure,
  input  logic               i_success,
  input  logic               i_eat,
  output logic [2:0]         o_state,
  output logic               o_run,
  output logic [1:0]         o_countdown,
  output logic [SCORE_W-1:0] o_score,
  output logic [SCORE_W-1:0] o_high,
  output logic               o_new_high,
  output logic               o_game_rst
);

  localparam int MAXF  = (COUNTDOWN_FRAMES > END_FRAMES) ? COUNTDOWN_FRAMES : END_FRAMES;
  localparam int CNT_W = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COUNTDOWN_FRAMES - 1);

  game_state_t          state_q, state_d;
  logic                 vsync_q, pause_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           cd_q, cd_d;
  logic                 run_q, run_d;
  logic [SCORE_W-1:0]   high_q, high_d;
  logic                 nh_q, nh_d;
  logic                 grst_q, grst_d;
  logic [SCORE_W-1:0]   score, score_next;
  logic                 frame_ev, pause_ev, cd_wrap, end_wrap;

  assign frame_ev = i_vsync & ~vsync_q;
  assign pause_ev = i_pause & ~pause_q;
  assign cd_wrap  = frame_ev && (cnt_q == CD_LAST);
`ifdef GAME_SEQ_AUTORESTART_EN
  localparam logic [CNT_W-1:0] END_LAST = CNT_W'(END_FRAMES - 1);
  assign end_wrap = frame_ev && (cnt_q == END_LAST);
`else
  assign end_wrap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vsync_q <= 1'b0;
      pause_q <= 1'b0;
      cnt_q   <= '0;
      cd_q    <= 2'd0;
      run_q   <= 1'b0;
      high_q  <= '0;
      nh_q    <= 1'b0;
      grst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= i_vsync;
      pause_q <= i_pause;
      cnt_q   <= cnt_d;
      cd_q    <= cd_d;
      run_q   <= run_d;
      high_q  <= high_d;
      nh_q    <= nh_d;
      grst_q  <= grst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_restart) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (i_start) state_d = ST_COUNT;
        ST_COUNT: if (cd_wrap && cd_q == 2'd1) state_d = ST_PLAY;
        ST_PLAY: begin
          if (i_failure)      state_d = ST_OVER;
          else if (i_success) state_d = ST_WIN;
          else if (pause_ev)  state_d = ST_PAUSE;
        end
        ST_PAUSE: if (pause_ev) state_d = ST_PLAY;
        ST_OVER, ST_WIN: if (end_wrap) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    cd_d   = cd_q;
    high_d = high_q;
    nh_d   = nh_q;
    grst_d = 1'b0;
    run_d  = (state_d == ST_PLAY);
    if (i_restart) begin
      cnt_d = '0;
      cd_d  = 2'd0;
      nh_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (state_d == ST_COUNT) begin
            cnt_d = '0;
            cd_d  = 2'd3;
          end
        end
        ST_COUNT: begin
          if (cd_wrap) begin
            cnt_d = '0;
            cd_d  = cd_q - 2'd1;
          end else if (frame_ev) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          // Packed BCD orders the same as binary, so a plain compare suffices.
          if (state_d == ST_OVER || state_d == ST_WIN) begin
            cnt_d = '0;
            nh_d  = (score_next > high_q);
            if (score_next > high_q) high_d = score_next;
          end
        end
        ST_OVER, ST_WIN: begin
`ifdef GAME_SEQ_AUTORESTART_EN
          if (end_wrap) begin
            cnt_d  = '0;
            grst_d = 1'b1;
            nh_d   = 1'b0;
          end else if (frame_ev) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (i_restart | grst_d),
    .i_inc   ((state_q == ST_PLAY) & i_eat & ~i_restart),
    .o_value (score),
    .o_next  (score_next)
  );

  assign o_state     = state_q;
  assign o_run       = run_q;
  assign o_countdown = cd_q;
  assign o_score     = score;
  assign o_high      = high_q;
  assign o_new_high  = nh_q;
  assign o_game_rst  = grst_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed, table-driven bench for game_sequencer with COUNTDOWN_FRAMES=2, END_FRAMES=3.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, restart, start, pause, vsync, failure, success, eat;
  logic [2:0]  state;
  logic        run, new_high, game_rst;
  logic [1:0]  countdown;
  logic [11:0] score, high;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  game_sequencer #(.COUNTDOWN_FRAMES(2), .END_FRAMES(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_restart   (restart),
    .i_start     (start),
    .i_pause     (pause),
    .i_vsync     (vsync),
    .i_failure   (failure),
    .i_success   (success),
    .i_eat       (eat),
    .o_state     (state),
    .o_run       (run),
    .o_countdown (countdown),
    .o_score     (score),
    .o_high      (high),
    .o_new_high  (new_high),
    .o_game_rst  (game_rst)
  );

  typedef struct {
    logic        rs, st, pa, vs, fa, su, ea;
    logic [2:0]  e_state;
    logic        e_run;
    logic [1:0]  e_cd;
    logic [11:0] e_score, e_high;
    logic        e_nh, e_grst;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rs, st, pa, vs, fa, su, ea,
                     input logic [2:0] es, input logic er, input logic [1:0] ec,
                     input logic [11:0] esc, input logic [11:0] eh,
                     input logic enh, input logic eg);
    vec_t v;
    v.rs = rs; v.st = st; v.pa = pa; v.vs = vs; v.fa = fa; v.su = su; v.ea = ea;
    v.e_state = es; v.e_run = er; v.e_cd = ec; v.e_score = esc; v.e_high = eh;
    v.e_nh = enh; v.e_grst = eg;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rs, st, pa, vs, fa, su, ea);
    restart = rs; start = st; pause = pa; vsync = vs; failure = fa; success = su; eat = ea;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] es, input logic er,
                           input logic [1:0] ec, input logic [11:0] esc,
                           input logic [11:0] eh, input logic enh, input logic eg);
    check({tag, ".state"}, {9'd0, state}, {9'd0, es});
    check({tag, ".run"}, {11'd0, run}, {11'd0, er});
    check({tag, ".countdown"}, {10'd0, countdown}, {10'd0, ec});
    check({tag, ".score"}, score, esc);
    check({tag, ".high"}, high, eh);
    check({tag, ".new_high"}, {11'd0, new_high}, {11'd0, enh});
    check({tag, ".game_rst"}, {11'd0, game_rst}, {11'd0, eg});
  endtask

  // start=1 then six vsync edges; countdown must end in PLAY
  task automatic run_to_play(input string tag);
    drive(0, 1, 0, 0, 0, 0, 0);
    step();
    check({tag, ".count_entry"}, {9'd0, state}, 12'd1);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0); step();
    end
    check({tag, ".play_state"}, {9'd0, state}, 12'd2);
    check({tag, ".play_run"}, {11'd0, run}, 12'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    // Start and countdown (st, run, cd, score, high, nh, grst)
    add(0,1,0,0,0,0,0, 3'd1,0,2'd3,12'h000,12'h000,0,0);
    add(0,1,0,1,0,0,0, 3'd1,0,2'd3,12'h000,12'h000,0,0);
    add(0,1,0,0,0,0,0, 3'd1,0,2'd3,12'h000,12'h000,0,0);
    add(0,0,0,1,0,0,0, 3'd1,0,2'd2,12'h000,12'h000,0,0);
    add(0,0,0,0,0,0,0, 3'd1,0,2'd2,12'h000,12'h000,0,0);
    add(0,0,0,1,0,0,0, 3'd1,0,2'd2,12'h000,12'h000,0,0);
    add(0,0,0,0,0,0,0, 3'd1,0,2'd2,12'h000,12'h000,0,0);
    add(0,0,0,1,0,0,0, 3'd1,0,2'd1,12'h000,12'h000,0,0);
    add(0,0,0,0,0,0,0, 3'd1,0,2'd1,12'h000,12'h000,0,0);
    add(0,0,0,1,0,0,0, 3'd1,0,2'd1,12'h000,12'h000,0,0);
    add(0,0,0,0,0,0,0, 3'd1,0,2'd1,12'h000,12'h000,0,0);
    add(0,0,0,1,0,0,0, 3'd2,1,2'd0,12'h000,12'h000,0,0);
    add(0,0,0,0,0,0,0, 3'd2,1,2'd0,12'h000,12'h000,0,0);
    // Eats in PLAY
    for (int i = 1; i <= 5; i++)
      add(0,0,0,0,0,0,1, 3'd2,1,2'd0,12'(i),12'h000,0,0);
    // Pause edge, held pause with eat, release with eat, second edge
    add(0,0,1,0,0,0,0, 3'd3,0,2'd0,12'h005,12'h000,0,0);
    add(0,0,1,0,0,0,1, 3'd3,0,2'd0,12'h005,12'h000,0,0);
    add(0,0,0,0,1,0,1, 3'd3,0,2'd0,12'h005,12'h000,0,0);
    add(0,0,1,0,0,0,0, 3'd2,1,2'd0,12'h005,12'h000,0,0);
    add(0,0,0,0,0,0,0, 3'd2,1,2'd0,12'h005,12'h000,0,0);
    // Failure and success together with a same-cycle eat
    add(0,0,0,0,1,1,1, 3'd4,0,2'd0,12'h006,12'h006,1,0);
    add(0,0,0,0,0,0,1, 3'd4,0,2'd0,12'h006,12'h006,1,0);
`ifndef GAME_SEQ_AUTORESTART_EN
    for (int i = 0; i < 10; i++) begin
      add(0,0,0,1,0,0,0, 3'd4,0,2'd0,12'h006,12'h006,1,0);
      add(0,0,0,0,0,0,0, 3'd4,0,2'd0,12'h006,12'h006,1,0);
    end
`endif

    repeat (3) step();
    check_all("reset", 3'd0, 0, 2'd0, 12'h000, 12'h000, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rs, tbl[i].st, tbl[i].pa, tbl[i].vs, tbl[i].fa, tbl[i].su, tbl[i].ea);
      step();
      check_all($sformatf("vec%0d", i), tbl[i].e_state, tbl[i].e_run, tbl[i].e_cd,
                tbl[i].e_score, tbl[i].e_high, tbl[i].e_nh, tbl[i].e_grst);
    end

`ifdef GAME_SEQ_AUTORESTART_EN
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0); step();
      check_all($sformatf("auto_edge%0d", i), 3'd4, 0, 2'd0, 12'h006, 12'h006, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0); step();
    end
    drive(0, 0, 0, 1, 0, 0, 0); step();
    check_all("auto_restart", 3'd0, 0, 2'd0, 12'h000, 12'h006, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0); step();
    check_all("auto_after", 3'd0, 0, 2'd0, 12'h000, 12'h006, 0, 0);
`endif

    // Restart clears all but the high score, even with start asserted
    drive(1, 1, 0, 0, 0, 0, 0); step();
    check_all("restart1", 3'd0, 0, 2'd0, 12'h000, 12'h006, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0); step();
    check_all("count2", 3'd1, 0, 2'd3, 12'h000, 12'h006, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 1); step();
    check_all("count_eat", 3'd1, 0, 2'd3, 12'h000, 12'h006, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0); step();
    check_all("restart_mid_count", 3'd0, 0, 2'd0, 12'h000, 12'h006, 0, 0);

    // Game 2: tie the high score and win; a tie is not a new high
    run_to_play("game2");
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1); step();
    end
    check("game2.score", score, 12'h006);
    drive(0, 0, 0, 0, 0, 1, 0); step();
    check_all("game2_win", 3'd5, 0, 2'd0, 12'h006, 12'h006, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0); step();

    // Game 3: BCD carries and saturation at 999
    run_to_play("game3");
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1); step();
    end
    check("game3.score10", score, 12'h010);
    for (int i = 0; i < 90; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1); step();
    end
    check("game3.score100", score, 12'h100);
    for (int i = 0; i < 899; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1); step();
    end
    check("game3.score999", score, 12'h999);
    drive(0, 0, 0, 0, 0, 0, 1); step();
    check("game3.saturate", score, 12'h999);
    drive(0, 0, 0, 0, 1, 0, 0); step();
    check_all("game3_over", 3'd4, 0, 2'd0, 12'h999, 12'h999, 1, 0);

    // Power-on reset clears the high score too
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0; step();
    check_all("final_reset", 3'd0, 0, 2'd0, 12'h000, 12'h000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level phase controller for the snake game. It sequences the session through idle, countdown, play, pause and end states, and gates the frame-rate tick enable that drives `tickgen`. It keeps a BCD score of apples eaten and a high score that survives game restarts. It sits in `game` between `control`/`snake`/`apple` (event sources) and `tickgen`/`vga` (consumers of `o_run`, `o_state`, score).

## Interface
Parameters:
- `COUNTDOWN_FRAMES`, default 60: frames per countdown step (1..1023).
- `END_FRAMES`, default 600: frames spent in OVER/WIN before auto-restart (1..1023).

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low. Clears everything, including the high score.
- `i_restart`, in, 1: level; game restart. Clears everything except the high score.
- `i_start`, in, 1: level; first user input latched by `control`.
- `i_pause`, in, 1: raw pause button level.
- `i_vsync`, in, 1: raw VGA vsync level.
- `i_failure`, in, 1: snake collision. Sampled in PLAY only.
- `i_success`, in, 1: board filled. Sampled in PLAY only.
- `i_eat`, in, 1: single-cycle apple-eaten pulse.
- `o_state`, out, 3: current `game_state_t`.
- `o_run`, out, 1: high iff state is PLAY. Gates the `tickgen` vsync input.
- `o_countdown`, out, 2: countdown digit 3..1 in COUNT, otherwise 0.
- `o_score`, out, 12: three BCD digits, score.
- `o_high`, out, 12: three BCD digits, high score.
- `o_new_high`, out, 1: the last finished game set a new high score.
- `o_game_rst`, out, 1: one-cycle auto-restart pulse. The top ORs it into `restart`.

## Operation
- **Frame event:** rising edge of `i_vsync`, detected against a registered copy. At most one per frame.
- **Pause event:** rising edge of `i_pause`, detected against a registered copy.
- **States:** IDLE=0, COUNT=1, PLAY=2, PAUSE=3, OVER=4, WIN=5.
- **IDLE:** `i_start`=1 → COUNT. Sets countdown=3 and clears the frame counter.
- **COUNT:** each frame event increments the frame counter. When the counter reaches `COUNTDOWN_FRAMES`-1 it wraps to 0 and the countdown decrements. A wrap while countdown=1 → PLAY with countdown=0.
- **PLAY:**
  - Priority order: `i_failure` → OVER, then `i_success` → WIN, then pause event → PAUSE.
  - `i_eat` increments the score in any cycle of PLAY, including the cycle of leaving PLAY.
- **PAUSE:** pause event → PLAY. `i_eat`, `i_failure` and `i_success` are ignored.
- **OVER/WIN entry cycle:**
  - If the score (including any same-cycle eat) > high: high ← score and `o_new_high` ← 1.
  - Equal scores do not set `o_new_high`.
- **OVER/WIN:** each frame event increments the frame counter. The frame where the counter reaches `END_FRAMES`-1 → IDLE, asserts `o_game_rst` for one cycle, clears the score and clears `o_new_high`.
- **Score:** 3-digit BCD incrementer with digit carry. Saturates at 999; an eat at 999 is ignored.
- **`i_restart`:** beats every other input in the same cycle. Next state is IDLE; score, countdown, frame counter and `o_new_high` clear. The high score is kept. The pause edge detector reloads from `i_pause`, so a held button does not fire.
- **`rst_n` low:** every output is 0, including `o_high`, and the state is IDLE.

## Timing
- All outputs are registered.
- A state change is visible on the cycle after the sampling edge where the input is high.
- `o_run` falls on the same edge OVER/WIN/PAUSE is entered. `tickgen` therefore sees no vsync in the frame after failure.
- Score updates one cycle after `i_eat`.
- Countdown total = 3×`COUNTDOWN_FRAMES` frame events from entry to COUNT.
- `o_game_rst` is high only in the cycle IDLE is entered from OVER/WIN.

## Configuration
- `GAME_SEQ_AUTORESTART_EN` defined: OVER/WIN time out as described.
- `GAME_SEQ_AUTORESTART_EN` undefined:
  - OVER/WIN hold until `i_restart` or `rst_n`.
  - The frame counter does not run in OVER/WIN.
  - `END_FRAMES` is unused and `o_game_rst` is tied to 0.

## Structure
- `game_pkg` holds `typedef enum logic [2:0] game_state_t`, `SCORE_DIGITS`=3 and `SCORE_W`=12.
- One sub-module, `bcd_counter`: N-digit BCD with `i_clr`, `i_inc` and saturation, `o_value`. Instantiated once for the score.
- The high-score compare is a plain unsigned compare, which is valid on packed BCD.

## Test plan
- **Start and countdown:** `COUNTDOWN_FRAMES`=2, `rst_n` released, `i_start`=1. `o_countdown` goes 3,2,1 every 2 vsync edges; after 6 edges state=PLAY and `o_run`=1.
- **Eat, failure, high score:** 5 `i_eat` pulses in PLAY gives `o_score`=0x005. Then `i_failure` gives state=OVER, `o_run`=0, `o_high`=0x005, `o_new_high`=1.
- **Pause:**
  - Pause edge in PLAY → PAUSE, and an `i_eat` there leaves the score unchanged.
  - Holding `i_pause` causes no toggle.
  - A second edge → PLAY.
- **Simultaneous and saturation:**
  - `i_failure` and `i_success` in the same cycle → OVER.
  - `i_eat` with score 999 → stays 0x999.
- **Auto-restart:** with the macro defined and `END_FRAMES`=3, 3 vsync edges after OVER give one `o_game_rst` pulse, state=IDLE, score=0 and high kept. Without the macro, state stays OVER after 10 edges.
- **Restart vs reset:** `i_restart` mid-COUNT → IDLE with high kept. Then `rst_n`=0 → `o_high`=0.
